timer_cmp: RTL and testbench

TIMER_CMP -- requirements
Module: timer_cmp

---
 rtl/timer_cmp.sv | 125 ++++++++++++
 tb/tb_timer_cmp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_cmp.sv
// Bus-mapped CNT_W-bit timer with compare, free-run/periodic/one-shot modes, overflow and snapshot.
// Define TIMER_CMP_IRQ_EN to build ctrl.irq_en and the registered irq output.
module timer_cmp #(
  parameter int unsigned CNT_W = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);
  localparam int unsigned HW = CNT_W - 32;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_FREE_ALT = 2'b11
  } mode_t;

  logic [CNT_W-1:0] count, count_nx, cmp;
  logic [CNT_W:0]   inc;
  logic [HW-1:0]    snap;
  logic [31:0]      snap_ext, cmp_hi_ext;
  logic [2:0]       a;
  logic             go, irq_en, st_match, st_ovf;
  mode_t            mode;
  logic             wr, rd, is_clear, is_load, is_match, ovf_set, w1c_match, w1c_ovf;
  logic             unused_bits;

  assign a         = addr[2:0];
  assign wr        = cs && write;
  assign rd        = cs && read;
  assign is_clear  = wr && (a == 3'd2) && wr_data[1];
  assign is_load   = wr && ((a == 3'd0) || (a == 3'd1));
  assign is_match  = go && (count == cmp) && !is_clear && !is_load;
  assign w1c_match = wr && (a == 3'd5) && wr_data[0];
  assign w1c_ovf   = wr && (a == 3'd5) && wr_data[1];
  assign inc       = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};

  // Priority: clear > load > match action > increment > hold.
  always_comb begin
    count_nx = count;
    ovf_set  = 1'b0;
    if (is_clear) begin
      count_nx = '0;
    end else if (is_load) begin
      if (a == 3'd0) count_nx[31:0] = wr_data;
      else           count_nx[CNT_W-1:32] = wr_data[HW-1:0];
    end else if (is_match && (mode == MODE_PERIODIC)) begin
      count_nx = '0;
    end else if (is_match && (mode == MODE_ONESHOT)) begin
      count_nx = count;
    end else if (go) begin
      count_nx = inc[CNT_W-1:0];
      ovf_set  = inc[CNT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      snap     <= '0;
      cmp      <= '1;
      go       <= 1'b0;
      mode     <= MODE_FREE;
      st_match <= 1'b0;
      st_ovf   <= 1'b0;
    end else begin
      count    <= count_nx;
      if (rd && (a == 3'd0)) snap <= count[CNT_W-1:32];
      // Set wins over a same-cycle write-1-to-clear.
      st_match <= (st_match && !w1c_match) || is_match;
      st_ovf   <= (st_ovf && !w1c_ovf) || ovf_set;
      if (wr && (a == 3'd2)) begin
        go   <= wr_data[0];
        mode <= mode_t'(wr_data[3:2]);
      end else if (is_match && (mode == MODE_ONESHOT)) begin
        go <= 1'b0;
      end
      if (wr && (a == 3'd3)) cmp[31:0] <= wr_data;
      if (wr && (a == 3'd4)) cmp[CNT_W-1:32] <= wr_data[HW-1:0];
    end
  end

`ifdef TIMER_CMP_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && (a == 3'd2)) irq_en <= wr_data[4];
      irq <= st_match && irq_en;
    end
  end
  assign unused_bits = ^addr[4:3];
`else
  assign irq_en      = 1'b0;
  assign irq         = 1'b0;
  assign unused_bits = ^{addr[4:3], wr_data[4]};
`endif

  always_comb begin
    snap_ext               = '0;
    snap_ext[HW-1:0]       = snap;
    cmp_hi_ext             = '0;
    cmp_hi_ext[HW-1:0]     = cmp[CNT_W-1:32];
  end

  always_comb begin
    case (a)
      3'd0:    rd_data = count[31:0];
      3'd1:    rd_data = snap_ext;
      3'd2:    rd_data = {27'd0, irq_en, mode, 1'b0, go};
      3'd3:    rd_data = cmp[31:0];
      3'd4:    rd_data = cmp_hi_ext;
      3'd5:    rd_data = {30'd0, st_ovf, st_match};
      default: rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_timer_cmp.sv
// Randomized bench for timer_cmp against a behavioural register-map model, plus literal scenario checks.
module tb_timer_cmp;
  localparam int unsigned CW = 48;
  localparam logic [63:0] MAX   = (64'd1 << CW) - 64'd1;
  localparam logic [63:0] HMASK = (64'd1 << (CW - 32)) - 64'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        irq;

  int unsigned n_chk = 0, n_pass = 0;
  logic        chk_en = 1'b0;

  logic [63:0] m_count, m_cmp, m_snap;
  logic [1:0]  m_mode;
  logic        m_go, m_en, m_match, m_ovf, m_irq;

  int unsigned seq [6] = '{1, 2, 3, 4, 0, 1};

  timer_cmp #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_count = '0; m_cmp = MAX; m_snap = '0; m_mode = 2'd0;
    m_go = 1'b0; m_en = 1'b0; m_match = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] ad);
    case (ad[2:0])
      3'd0:    return m_count[31:0];
      3'd1:    return m_snap[31:0];
      3'd2:    return {27'd0, m_en, m_mode, 1'b0, m_go};
      3'd3:    return m_cmp[31:0];
      3'd4:    return m_cmp[63:32];
      3'd5:    return {30'd0, m_ovf, m_match};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the register map, computed from the pre-edge model state.
  task automatic model_edge(input logic c, input logic r, input logic w,
                            input logic [4:0] ad, input logic [31:0] d);
    logic wr, rd, clr, ld, mt, ovs;
    logic [2:0] a;
    logic [63:0] n;
    wr = c && w; rd = c && r; a = ad[2:0];
    clr = wr && (a == 3'd2) && d[1];
    ld  = wr && (a <= 3'd1);
    mt  = m_go && (m_count == m_cmp) && !clr && !ld;
    n = m_count; ovs = 1'b0;
    if (clr) n = '0;
    else if (ld && a == 3'd0) n = (m_count & 64'hFFFF_FFFF_0000_0000) | 64'(d);
    else if (ld) n = (m_count & 64'h0000_0000_FFFF_FFFF) | ((64'(d) & HMASK) << 32);
    else if (mt && m_mode == 2'd1) n = '0;
    else if (mt && m_mode == 2'd2) n = m_count;
    else if (m_go) begin
      if (m_count == MAX) begin n = '0; ovs = 1'b1; end
      else n = m_count + 64'd1;
    end
`ifdef TIMER_CMP_IRQ_EN
    m_irq = m_match && m_en;
`else
    m_irq = 1'b0;
`endif
    if (rd && a == 3'd0) m_snap = m_count >> 32;
    m_match = (m_match && !(wr && a == 3'd5 && d[0])) || mt;
    m_ovf   = (m_ovf && !(wr && a == 3'd5 && d[1])) || ovs;
    if (wr && a == 3'd2) begin
      m_go = d[0]; m_mode = d[3:2];
`ifdef TIMER_CMP_IRQ_EN
      m_en = d[4];
`endif
    end else if (mt && m_mode == 2'd2) m_go = 1'b0;
    if (wr && a == 3'd3) m_cmp = (m_cmp & 64'hFFFF_FFFF_0000_0000) | 64'(d);
    if (wr && a == 3'd4) m_cmp = (m_cmp & 64'h0000_0000_FFFF_FFFF) | ((64'(d) & HMASK) << 32);
    m_count = n;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data", 64'(rd_data), 64'(m_read(addr)));
      check("irq", 64'(irq), 64'(m_irq));
    end
  end

  task automatic step(input logic c, input logic r, input logic w,
                      input logic [4:0] ad, input logic [31:0] d, output logic [31:0] v);
    cs = c; read = r; write = w; addr = ad; wr_data = d;
    #1 v = rd_data;
    @(posedge clk);
    model_edge(c, r, w, ad, d);
    #1;
  endtask

  task automatic wreg(input logic [4:0] ad, input logic [31:0] d);
    logic [31:0] v;
    step(1'b1, 1'b0, 1'b1, ad, d, v);
  endtask

  task automatic rreg(input logic [4:0] ad, output logic [31:0] v);
    step(1'b1, 1'b1, 1'b0, ad, 32'd0, v);
  endtask

  task automatic idle();
    logic [31:0] v;
    step(1'b0, 1'b0, 1'b0, addr, 32'd0, v);
  endtask

  task automatic expect_reg(input string name, input logic [4:0] ad, input logic [31:0] exp);
    cs = 1'b0; read = 1'b0; write = 1'b0; addr = ad;
    #1 check(name, 64'(rd_data), 64'(exp));
  endtask

  task automatic do_reset();
    cs = 1'b0; read = 1'b0; write = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    expect_reg("rst_count", 5'd0, 32'd0);
    expect_reg("rst_status", 5'd5, 32'd0);
    expect_reg("rst_ctrl", 5'd2, 32'd0);
    check("rst_irq", 64'(irq), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    logic [31:0] lo, hi, d;
    logic [4:0] ad;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_reg("reset_count_lo", 5'd0, 32'd0);
    expect_reg("reset_snap", 5'd1, 32'd0);
    expect_reg("reset_ctrl", 5'd2, 32'd0);
    expect_reg("reset_cmp_lo", 5'd3, 32'hFFFF_FFFF);
    expect_reg("reset_cmp_hi", 5'd4, 32'h0000_FFFF);
    expect_reg("reset_status", 5'd5, 32'd0);
    expect_reg("reset_addr7", 5'd7, 32'd0);
    check("reset_irq", 64'(irq), 64'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    // Free-run: ten edges after go is written the count reads 10.
    wreg(5'd2, 32'h1);
    repeat (10) idle();
    expect_reg("free_run_count", 5'd0, 32'd10);
    wreg(5'd2, 32'h2);

    // Periodic reload at cmp=4.
    wreg(5'd3, 32'd4);
    wreg(5'd4, 32'd0);
    wreg(5'd2, 32'h5);
    for (int i = 0; i < 6; i++) begin
      idle();
      expect_reg("periodic_count", 5'd0, seq[i]);
    end
    expect_reg("periodic_status", 5'd5, 32'h1);
`ifdef TIMER_CMP_IRQ_EN
    wreg(5'd2, 32'h15);
    check("irq_delay", 64'(irq), 64'd0);
    idle();
    check("irq_set", 64'(irq), 64'd1);
    wreg(5'd2, 32'h10);
    wreg(5'd5, 32'h1);
    check("irq_hold", 64'(irq), 64'd1);
    idle();
    check("irq_clear", 64'(irq), 64'd0);
`else
    wreg(5'd2, 32'h15);
    expect_reg("ctrl_irq_en_masked", 5'd2, 32'h5);
    wreg(5'd2, 32'h0);
    wreg(5'd5, 32'h1);
    check("irq_tied", 64'(irq), 64'd0);
`endif
    wreg(5'd2, 32'h2);

    // One-shot stops at cmp and drops go.
    wreg(5'd3, 32'd3);
    wreg(5'd2, 32'h9);
    repeat (24) idle();
    expect_reg("oneshot_count", 5'd0, 32'd3);
    expect_reg("oneshot_ctrl", 5'd2, 32'h8);
    expect_reg("oneshot_status", 5'd5, 32'h1);

    // Reset in the middle of a one-shot run.
    wreg(5'd5, 32'h3);
    wreg(5'd2, 32'h2);
    wreg(5'd2, 32'h9);
    idle(); idle();
    do_reset();
    expect_reg("post_reset_cmp_hi", 5'd4, 32'h0000_FFFF);

    // Clear beats a same-cycle match.
    wreg(5'd3, 32'd5);
    wreg(5'd4, 32'd0);
    wreg(5'd2, 32'h5);
    repeat (5) idle();
    expect_reg("clr_pre_count", 5'd0, 32'd5);
    wreg(5'd2, 32'h7);
    expect_reg("clr_count", 5'd0, 32'd0);
    expect_reg("clr_status", 5'd5, 32'd0);
    wreg(5'd2, 32'h2);

    // Overflow wrap from all ones.
    wreg(5'd0, 32'hFFFF_FFFF);
    wreg(5'd1, 32'h0000_FFFF);
    wreg(5'd2, 32'h1);
    idle();
    expect_reg("ovf_count", 5'd0, 32'd0);
    expect_reg("ovf_status", 5'd5, 32'h2);
    wreg(5'd2, 32'h2);
    wreg(5'd5, 32'h3);

    // Snapshot gives a coherent pair across a low-word carry.
    wreg(5'd1, 32'h1);
    wreg(5'd0, 32'hFFFF_FFFE);
    wreg(5'd2, 32'h1);
    idle();
    rreg(5'd0, lo);
    idle(); idle();
    rreg(5'd1, hi);
    check("snap_lo", 64'(lo), 64'hFFFF_FFFF);
    check("snap_hi", 64'(hi), 64'h1);
    wreg(5'd2, 32'h2);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      ad = 5'($urandom_range(0, 31));
      d = $urandom;
      case (ad[2:0])
        3'd0: d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 30));
        3'd1: d = ($urandom_range(0, 3) == 0) ? 32'h0000_FFFF : 32'($urandom_range(0, 2));
        3'd2: begin
          d = d & 32'h1F;
          if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
        end
        3'd3: d = 32'($urandom_range(0, 40));
        3'd4: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        default: ;
      endcase
      step($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad, d, lo);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
